display_7seg_scan: RTL and testbench
====================================

Name: display_7seg_scan

Overview:
- Time-multiplexed driver for NUM_DIGITS common-anode 7-segment digits with per-digit decimal points.
- Accepts a packed hex word through a load strobe, double-buffers it so updates never tear mid-frame, and scans one digit at a time.
- Optional leading-zero blanking.
- Sits between the datapath (counters, registers under display) and the board display pins; generalises the single-digit hex decoder to N scanned digits.

Parameters:
- NUM_DIGITS, 4, digit count (2..8).
- DIGIT_PERIOD, 100000, clock cycles each digit stays lit (≥2).
- CNT_W, $clog2(DIGIT_PERIOD), prescaler width (derived, localparam).
- IDX_W, $clog2(NUM_DIGITS), digit index width (derived, localparam).

Ports:
- clk, in, 1: system clock, all logic on rising edge.
- rst, in, 1: asynchronous active-high reset.
- load, in, 1: one-cycle strobe; capture value and dp_in.
- value, in, 4*NUM_DIGITS: hex nibbles; nibble k = digit k, digit 0 = rightmost.
- dp_in, in, NUM_DIGITS: decimal point request per digit, 1 = lit.
- blank_lz, in, 1: enable leading-zero blanking (level).
- enable, in, 1: 0 = display dark, scanning continues.
- seg, out, 7: segments g..a = seg[6:0], active-low.
- dp, out, 1: decimal point, active-low.
- an, out, NUM_DIGITS: digit anodes, active-low one-hot.
- frame_done, out, 1: one-cycle pulse when last digit's slot ends.

Behaviour:
- Reset (async, rst=1): seg=7'h7F, dp=1, an=all ones, frame_done=0, prescaler=0, idx=0, active/pending value and dp regs=0, pending_valid=0.
- Prescaler counts 0..DIGIT_PERIOD-1. tick = (cnt==DIGIT_PERIOD-1). On tick: cnt←0, idx←(idx==NUM_DIGITS-1)?0:idx+1.
- Frame boundary = tick with idx==NUM_DIGITS-1. frame_done=1 in the cycle after the boundary.
- Outputs are registered from current idx and active regs; change one cycle after idx changes.
- After reset release: digit 0 is driven from the 1st cycle.
- load: value/dp_in captured into pending regs; pending_valid←1. A second load before the boundary overwrites pending.
- At frame boundary with pending_valid=1: active←pending, pending_valid←0.
- load in the same cycle as the boundary: the new data goes straight to active, and pending_valid ends 0.
- Decode, active-low, bit order g..a:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
  - All 16 codes are explicit; no default-dependent glyph.
- Leading-zero blanking (blank_lz=1): digit k is blanked if nibbles k..NUM_DIGITS-1 of active are all zero and k≠0.
  - Digit 0 is never blanked.
  - A blanked digit gives seg=7'h7F; its anode is still asserted and dp still follows dp_in.
- enable=0: an=all ones, seg=7'h7F, dp=1 from the next cycle. Prescaler, idx and buffering keep running. Re-enable resumes at the current idx.
- Only one an bit is low at any time; no overlap between digits.
- blank_lz changes take effect on the next registered output update.
- Reset mid-scan: immediate return to reset values and pending data discarded; display shows 0 on digit 0 only if blank_lz=1, else 0000.

Decomposition:
- Package seg7_pkg:
  - SEG_BLANK constant (7'h7F).
  - 16-entry hex→segment constant table, or function hex_to_seg.
  - typedef seg_t (logic [6:0]).
- Sub-module seg7_decode: combinational nibble→seg_t using the package table. Instantiate once, fed by the muxed nibble.
- Scanner, buffering and blanking logic stay in display_7seg_scan.

Test Plan (NUM_DIGITS=4, DIGIT_PERIOD=4):
- Hold rst=1 → seg=7F, dp=1, an=F, frame_done=0. Release → first load of 0x0000 with blank_lz=0 → an cycles E,D,B,7, each for 4 clks; seg=1000000 on every digit.
- load value=0x12AF, dp_in=0100 → after next boundary, scan shows:
  - an=E seg=0001110
  - an=D seg=0001000
  - an=B seg=0100100, dp=0
  - an=7 seg=1111001
  - frame_done pulses once per 16 clks.
- load 0x0050 with blank_lz=1 → digits 3,2 show seg=7F with anode low; digit1=0010010, digit0=1000000. Set blank_lz=0 → digits 3,2 show 1000000.
- load 0x1111 while idx=1 → digits keep old data until the boundary, then all read 1111001. A second load of 0x2222 before the boundary → only 0x2222 appears.
- enable=0 mid-frame → an=F, seg=7F next cycle; frame_done continues every 16 clks. enable=1 → resumes at the in-progress idx.
- Assert rst during digit 2 slot → outputs return to reset values asynchronously (same cycle); pending load discarded; scan restarts at digit 0.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared types and glyph table for 7-segment display drivers.
// Pure constants and a combinational helper; no state, no latency.
// No handshake; consumers index the table directly.
package seg7_pkg;

    // Segment vector, bit order g..a = [6:0], active-low.
    typedef logic [6:0] seg_t;

    // All segments off.
    localparam seg_t SEG_BLANK = 7'h7F;

    // Hex nibble to active-low glyph. Every code is spelled out so no glyph
    // depends on a fall-through default.
    function automatic seg_t hex_to_seg(input logic [3:0] nib);
        seg_t s;
        case (nib)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            4'hF: s = 7'b0001110;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Nibble to active-low 7-segment glyph.
// Combinational, zero latency.
// No flow control; output follows input continuously.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Table lookup of the currently selected digit's nibble.
    always_comb begin
        seg = hex_to_seg(nibble);
    end

endmodule

// File: rtl/display_7seg_scan.sv
// Time-multiplexed driver for NUM_DIGITS common-anode digits with tear-free double buffering.
// Outputs registered: one cycle after the scan index moves; frame_done one cycle after the last slot ends.
// No backpressure: load is a strobe, data parks in a pending buffer until the next frame boundary.
module display_7seg_scan
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int DIGIT_PERIOD = 100000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank_lz,
    input  logic                    enable,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int CNT_W = $clog2(DIGIT_PERIOD);
    localparam int IDX_W = $clog2(NUM_DIGITS);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGIT_PERIOD - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_ONE = NUM_DIGITS'(1);

    // Scan state
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    logic             tick;
    logic             boundary;

    // Double buffer: pending collects loads, active feeds the display
    logic [4*NUM_DIGITS-1:0] active_value;
    logic [NUM_DIGITS-1:0]   active_dp;
    logic [4*NUM_DIGITS-1:0] pending_value;
    logic [NUM_DIGITS-1:0]   pending_dp;
    logic                    pending_valid;

    // Per-digit datapath
    logic [3:0]            cur_nibble;
    seg_t                  dec_seg;
    logic [NUM_DIGITS-1:0] lz_mask;
    logic                  zero_run;

    assign tick     = (cnt == CNT_LAST);
    assign boundary = tick && (idx == IDX_LAST);

    // Prescaler and digit index: each digit holds for DIGIT_PERIOD cycles, index wraps after the last digit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (tick) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Double buffering: the active copy only changes at a frame boundary so a frame never mixes old and new data.
    // A load coinciding with the boundary bypasses pending and lands directly in active.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_value  <= '0;
            active_dp     <= '0;
            pending_value <= '0;
            pending_dp    <= '0;
            pending_valid <= 1'b0;
        end else begin
            if (load) begin
                pending_value <= value;
                pending_dp    <= dp_in;
            end
            if (boundary) begin
                pending_valid <= 1'b0;
                if (load) begin
                    active_value <= value;
                    active_dp    <= dp_in;
                end else if (pending_valid) begin
                    active_value <= pending_value;
                    active_dp    <= pending_dp;
                end
            end else if (load) begin
                pending_valid <= 1'b1;
            end
        end
    end

    // Select the nibble for the digit currently being scanned.
    always_comb begin
        cur_nibble = active_value[{idx, 2'b00} +: 4];
    end

    seg7_decode u_decode (
        .nibble (cur_nibble),
        .seg    (dec_seg)
    );

    // Leading-zero mask: digit k is a leading zero when it and every digit above it are zero.
    // Digit 0 is never part of the mask so a zero value still shows a single 0.
    always_comb begin
        zero_run = 1'b1;
        lz_mask  = '0;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            zero_run   = zero_run & (active_value[4*k +: 4] == 4'h0);
            lz_mask[k] = zero_run;
        end
    end

    // Registered pin drivers: one anode low at a time, everything dark when disabled, frame pulse after the last slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg        <= SEG_BLANK;
            dp         <= 1'b1;
            an         <= '1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= boundary;
            if (!enable) begin
                seg <= SEG_BLANK;
                dp  <= 1'b1;
                an  <= '1;
            end else begin
                seg <= (blank_lz && lz_mask[idx]) ? SEG_BLANK : dec_seg;
                dp  <= ~active_dp[idx];
                an  <= ~(AN_ONE << idx);
            end
        end
    end

endmodule

// File: tb/tb_display_7seg_scan.sv
// Randomized and directed bench for display_7seg_scan with a cycle-count based reference model.
// Model predicts pins after each rising edge; compared on every falling edge.
// Waits on DUT events are cycle-bounded.
module tb_display_7seg_scan;

    localparam int N = 4;
    localparam int P = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          load;
    logic [4*N-1:0] value;
    logic [N-1:0]  dp_in;
    logic          blank_lz;
    logic          enable;
    logic [6:0]    seg;
    logic          dp;
    logic [N-1:0]  an;
    logic          frame_done;

    int vectors = 0;
    int errors  = 0;
    bit run_chk = 1'b0;

    display_7seg_scan #(.NUM_DIGITS(N), .DIGIT_PERIOD(P)) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .value      (value),
        .dp_in      (dp_in),
        .blank_lz   (blank_lz),
        .enable     (enable),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    logic [6:0] seg_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // Reference model: scan position derived purely from the edge count since reset.
    int             m_n = 0;
    int             m_idx;
    bit             m_bnd;
    logic [4*N-1:0] m_act = '0;
    logic [N-1:0]   m_actdp = '0;
    logic [4*N-1:0] m_pend = '0;
    logic [N-1:0]   m_penddp = '0;
    bit             m_pv = 1'b0;
    logic [3:0]     m_nib;
    logic [6:0]     e_seg = 7'h7F;
    logic           e_dp = 1'b1;
    logic [N-1:0]   e_an = '1;
    logic           e_fd = 1'b0;

    task automatic model_step();
        if (rst) begin
            m_n = 0; m_act = '0; m_actdp = '0; m_pend = '0; m_penddp = '0; m_pv = 1'b0;
            e_seg = 7'h7F; e_dp = 1'b1; e_an = '1; e_fd = 1'b0;
        end else begin
            m_idx = (m_n / P) % N;
            m_bnd = (m_n % (P * N)) == (P * N - 1);
            if (!enable) begin
                e_seg = 7'h7F; e_dp = 1'b1; e_an = '1;
            end else begin
                m_nib = 4'(m_act >> (4 * m_idx));
                if (blank_lz && m_idx != 0 && (m_act >> (4 * m_idx)) == 0)
                    e_seg = 7'h7F;
                else
                    e_seg = seg_tab[m_nib];
                e_dp = !m_actdp[m_idx];
                e_an = ~(N'(1) << m_idx);
            end
            e_fd = m_bnd;
            if (m_bnd) begin
                if (load) begin
                    m_act = value; m_actdp = dp_in;
                end else if (m_pv) begin
                    m_act = m_pend; m_actdp = m_penddp;
                end
                m_pv = 1'b0;
            end else if (load) begin
                m_pend = value; m_penddp = dp_in; m_pv = 1'b1;
            end
            m_n++;
        end
    endtask

    always begin
        @(posedge clk or posedge rst);
        model_step();
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always begin
        @(negedge clk);
        if (run_chk) begin
            check("model_seg", 32'(seg), 32'(e_seg));
            check("model_dp", 32'(dp), 32'(e_dp));
            check("model_an", 32'(an), 32'(e_an));
            check("model_fd", 32'(frame_done), 32'(e_fd));
        end
    end

    task automatic tick();
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_fd();
        bit got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            tick();
            got = (frame_done === 1'b1);
        end
        check("wait_frame_done", 32'(frame_done), 32'd1);
    endtask

    task automatic wait_an(input logic [N-1:0] target);
        bit got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            tick();
            got = (an === target);
        end
        check("wait_anode", 32'(an), 32'(target));
    endtask

    // Literal expectations for one whole frame starting at digit 0.
    task automatic check_frame(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                               input logic [6:0] s3, input logic [N-1:0] dreq);
        logic [6:0]   s [4];
        logic [N-1:0] an_seq [4];
        logic         exp_dp;
        int           d;
        s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
        an_seq[0] = 4'hE; an_seq[1] = 4'hD; an_seq[2] = 4'hB; an_seq[3] = 4'h7;
        for (int i = 0; i < 16; i++) begin
            tick();
            d = i / 4;
            exp_dp = !dreq[d];
            check("frame_an", 32'(an), 32'(an_seq[d]));
            check("frame_seg", 32'(seg), 32'(s[d]));
            check("frame_dp", 32'(dp), 32'(exp_dp));
            check("frame_fd", 32'(frame_done), (i == 15) ? 32'd1 : 32'd0);
        end
    endtask

    int fd_count;

    initial begin
        rst = 1'b1; load = 1'b0; value = '0; dp_in = '0; blank_lz = 1'b0; enable = 1'b1;
        repeat (3) @(negedge clk);
        run_chk = 1'b1;
        check("reset_seg", 32'(seg), 32'h7F);
        check("reset_dp", 32'(dp), 32'd1);
        check("reset_an", 32'(an), 32'hF);
        check("reset_fd", 32'(frame_done), 32'd0);

        // Release and scan a zero value.
        rst = 1'b0; load = 1'b1; value = 16'h0000;
        check_frame(7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000, 4'b0000);

        // Mixed glyphs with one decimal point.
        load = 1'b1; value = 16'h12AF; dp_in = 4'b0100;
        wait_fd();
        check_frame(7'b0001110, 7'b0001000, 7'b0100100, 7'b1111001, 4'b0100);

        // Leading-zero blanking, then blanking off.
        load = 1'b1; value = 16'h0050; dp_in = 4'b0000; blank_lz = 1'b1;
        wait_fd();
        check_frame(7'b1000000, 7'b0010010, 7'h7F, 7'h7F, 4'b0000);
        blank_lz = 1'b0;
        check_frame(7'b1000000, 7'b0010010, 7'b1000000, 7'b1000000, 4'b0000);

        // Mid-frame load, then a second load overwriting pending.
        repeat (5) tick();
        load = 1'b1; value = 16'h1111;
        wait_fd();
        check_frame(7'b1111001, 7'b1111001, 7'b1111001, 7'b1111001, 4'b0000);
        repeat (5) tick();
        load = 1'b1; value = 16'h1111;
        repeat (3) tick();
        load = 1'b1; value = 16'h2222;
        wait_fd();
        check_frame(7'b0100100, 7'b0100100, 7'b0100100, 7'b0100100, 4'b0000);

        // Load landing exactly on the frame boundary.
        repeat (15) tick();
        load = 1'b1; value = 16'h0789; dp_in = 4'b0001;
        tick();
        check("bnd_load_fd", 32'(frame_done), 32'd1);
        check_frame(7'b0010000, 7'b0000000, 7'b1111000, 7'b1000000, 4'b0001);

        // Disable mid-frame: dark pins, frame pulses continue.
        repeat (6) tick();
        enable = 1'b0;
        tick();
        check("dis_an", 32'(an), 32'hF);
        check("dis_seg", 32'(seg), 32'h7F);
        fd_count = 0;
        for (int i = 0; i < 32; i++) begin
            tick();
            if (frame_done === 1'b1) fd_count++;
        end
        check("dis_fd_count", 32'(fd_count), 32'd2);
        enable = 1'b1;
        repeat (8) tick();

        // Asynchronous reset during digit 2 with a load still pending.
        wait_fd();
        load = 1'b1; value = 16'h3333; dp_in = 4'b1111;
        wait_an(4'hB);
        #3 rst = 1'b1;
        #1;
        check("arst_an", 32'(an), 32'hF);
        check("arst_seg", 32'(seg), 32'h7F);
        check("arst_dp", 32'(dp), 32'd1);
        @(negedge clk);
        rst = 1'b0; blank_lz = 1'b1;
        check_frame(7'b1000000, 7'h7F, 7'h7F, 7'h7F, 4'b0000);
        check_frame(7'b1000000, 7'h7F, 7'h7F, 7'h7F, 4'b0000);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst   = ($urandom % 400) == 0;
            load  = ($urandom % 6) == 0;
            value = 16'($urandom);
            if (($urandom % 3) == 0) value = value & 16'h00FF;
            dp_in = 4'($urandom);
            if (($urandom % 40) == 0) blank_lz = ~blank_lz;
            if (($urandom % 50) == 0) enable = ~enable;
        end
        @(negedge clk);
        rst = 1'b0; load = 1'b0;
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
